// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO reader: controller states,
// the default data width and the read-admission arithmetic.
package fifo_reader_pkg;

    localparam int FIFO_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Words that will occupy the buffer once the in-flight read lands and
    // the current handshake retires; a new read is only safe while this is < 2.
    function automatic logic [2:0] pending_words(
        input logic [1:0] occ,
        input logic       inflight,
        input logic       handshake
    );
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, handshake};
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer; head_data is the oldest word held.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       occ_r;

    // Buffer update; push and pop together keep occupancy and shift order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= '0;
            tail_r <= '0;
            occ_r  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_r <= push_data;
                        occ_r  <= 2'd1;
                    end else if (occ_r == 2'd1) begin
                        tail_r <= push_data;
                        occ_r  <= 2'd2;
                    end else begin
                        occ_r  <= occ_r;
                    end
                end
                2'b01: begin
                    head_r <= tail_r;
                    occ_r  <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        head_r <= push_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign head_data = head_r;
    assign occ       = occ_r;

endmodule

// File: rtl/fifo_reader.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry
// buffer, with run/flush control, a handshake counter and a sticky error.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [15:0]           words_out,
    output logic                  underflow_err,
    output logic                  done
);

    state_t                state_r;
    logic                  inflight_r;
    logic [15:0]           words_r;
    logic                  err_r;
    logic                  done_r;

    logic [1:0]            occ_s;
    logic [FIFO_WIDTH-1:0] head_s;
    logic                  hs_s;
    logic                  push_s;
    logic                  rd_en_s;
    logic                  drained_s;

    // Read admission, capture qualification and drain detection.
    always_comb begin
        hs_s      = 1'b0;
        push_s    = 1'b0;
        rd_en_s   = 1'b0;
        drained_s = 1'b0;
        hs_s      = (occ_s != 2'd0) && m_ready;
        push_s    = inflight_r && !fifo_underflow;
        drained_s = !inflight_r && (occ_s == 2'd0);
        if ((state_r == RUN) && !fifo_empty &&
            (pending_words(occ_s, inflight_r, hs_s) < 3'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Control state machine; done marks the cycle after a flush completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (enable) state_r <= RUN;
                end
                RUN: begin
                    if (!enable) state_r <= FLUSH;
                end
                FLUSH: begin
                    if (enable) begin
                        state_r <= RUN;
                    end else if (drained_s) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Read tracking, handshake count and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
            words_r    <= 16'd0;
            err_r      <= 1'b0;
        end else begin
            inflight_r <= rd_en_s;
            if (hs_s) words_r <= words_r + 16'd1;
            if (inflight_r && fifo_underflow) err_r <= 1'b1;
        end
    end

    fifo_reader_skid #(
        .WIDTH(FIFO_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_s),
        .push_data(fifo_data_out),
        .pop      (hs_s),
        .head_data(head_s),
        .occ      (occ_s)
    );

    assign fifo_rd_en    = rd_en_s;
    assign m_valid       = (occ_s != 2'd0);
    assign m_data        = head_s;
    assign words_out     = words_r;
    assign underflow_err = err_r;
    assign done          = done_r;

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a queue-based FIFO model feeds the DUT
// and every delivered word is checked against the order words were loaded.
module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_underflow = 1'b0;
    logic [15:0] fifo_data_out = 16'h0000;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic [15:0] words_out;
    logic        underflow_err;
    logic        done;

    logic [15:0] fq[$];
    logic [15:0] exp_q[$];
    logic        force_uf = 1'b0;
    int          rd_count = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    fifo_reader #(.FIFO_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .fifo_data_out(fifo_data_out),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .words_out(words_out), .underflow_err(underflow_err),
        .done(done)
    );

    // FIFO model: data and underflow appear the cycle after a read strobe.
    always @(posedge clk) begin
        fifo_underflow <= fifo_rd_en & force_uf;
        if (fifo_rd_en) begin
            rd_count++;
            if (fq.size() > 0) fifo_data_out <= fq.pop_front();
            else fifo_data_out <= 16'hDEAD;
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic do_reset();
        enable = 1'b0; m_ready = 1'b0; force_uf = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        fq.delete(); exp_q.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_words(input int n, input bit rnd, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = rnd ? 16'($urandom) : base + 16'(i);
            fq.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic check_all_zero(input string tag);
        tests_run++;
        if ({fifo_rd_en, m_valid, m_data, words_out, underflow_err, done} !== 36'd0) begin
            tests_failed++;
            $display("FAIL %s: rd_en=%b valid=%b data=%h words=%h err=%b done=%b required all 0",
                     tag, fifo_rd_en, m_valid, m_data, words_out, underflow_err, done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_all_zero("reset_outputs");
    endtask

    task automatic test_stream();
        int first_rd = -1, first_v = -1, hs = 0, prev = 0, gaps = 0, rd0;
        logic [15:0] e;
        do_reset();
        load_words(8, 1'b0, 16'h0001);
        rd0 = rd_count; m_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 60 && hs < 8; c++) begin
            @(negedge clk);
            if (fifo_rd_en && first_rd < 0) first_rd = c;
            if (m_valid && first_v < 0) first_v = c;
            if (m_valid && m_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hBEEF;
                tests_run++;
                if (m_data !== e) begin
                    tests_failed++;
                    $display("FAIL stream_data: got %h required %h", m_data, e);
                end
                if (hs > 0 && c != prev + 1) gaps++;
                prev = c; hs++;
            end
        end
        @(negedge clk);
        tests_run++;
        if (hs != 8) begin tests_failed++; $display("FAIL stream_count: got %0d required 8", hs); end
        tests_run++;
        if (first_v - first_rd != 2) begin
            tests_failed++; $display("FAIL stream_latency: got %0d required 2", first_v - first_rd);
        end
        tests_run++;
        if (gaps != 0) begin tests_failed++; $display("FAIL stream_gaps: got %0d required 0", gaps); end
        tests_run++;
        if (words_out !== 16'd8) begin
            tests_failed++; $display("FAIL stream_words_out: got %0d required 8", words_out);
        end
        tests_run++;
        if (rd_count - rd0 != 8) begin
            tests_failed++; $display("FAIL stream_reads: got %0d required 8", rd_count - rd0);
        end
    endtask

    task automatic test_backpressure();
        int rd0, hs = 0, waited = 0;
        logic [15:0] held, e;
        do_reset();
        load_words(4, 1'b1, 16'h0000);
        rd0 = rd_count; m_ready = 1'b0; enable = 1'b1;
        do begin @(negedge clk); waited++; end while (!m_valid && waited < 20);
        tests_run++;
        if (!m_valid || m_data !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL bp_first: valid=%b data=%h required valid=1 data=%h", m_valid, m_data, exp_q[0]);
        end
        held = m_data;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (!m_valid || m_data !== held) begin
                tests_failed++;
                $display("FAIL bp_hold: valid=%b data=%h required valid=1 data=%h", m_valid, m_data, held);
            end
        end
        tests_run++;
        if (rd_count - rd0 > 2) begin
            tests_failed++; $display("FAIL bp_reads: got %0d required at most 2", rd_count - rd0);
        end
        for (int c = 0; c < 40 && hs < 4; c++) begin
            m_ready = 1'b1;
            if (m_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hBEEF;
                tests_run++;
                if (m_data !== e) begin
                    tests_failed++; $display("FAIL bp_data: got %h required %h", m_data, e);
                end
                hs++;
            end
            @(negedge clk);
        end
        tests_run++;
        if (hs != 4 || words_out !== 16'd4) begin
            tests_failed++; $display("FAIL bp_total: got hs=%0d words=%0d required 4", hs, words_out);
        end
    endtask

    task automatic test_flush();
        int rd0, hs = 0, waited = 0, extra_rd = 0, done_cnt = 0;
        logic [15:0] e;
        do_reset();
        load_words(4, 1'b1, 16'h0000);
        rd0 = rd_count; m_ready = 1'b0; enable = 1'b1;
        do begin @(negedge clk); waited++; end while (!m_valid && waited < 20);
        enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            if (fifo_rd_en) extra_rd++;
            if (done) done_cnt++;
            if (m_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hBEEF;
                tests_run++;
                if (m_data !== e) begin
                    tests_failed++; $display("FAIL flush_data: got %h required %h", m_data, e);
                end
                hs++;
            end
        end
        tests_run++;
        if (hs != 2) begin tests_failed++; $display("FAIL flush_delivered: got %0d required 2", hs); end
        tests_run++;
        if (extra_rd != 0 || rd_count - rd0 != 2) begin
            tests_failed++;
            $display("FAIL flush_reads: extra=%0d total=%0d required 0 and 2", extra_rd, rd_count - rd0);
        end
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("FAIL flush_done: got %0d pulses required 1", done_cnt); end
        tests_run++;
        if (words_out !== 16'd2) begin
            tests_failed++; $display("FAIL flush_words_out: got %0d required 2", words_out);
        end
    endtask

    task automatic test_empty();
        int rd_seen = 0, v_seen = 0;
        do_reset();
        m_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_seen++;
            if (m_valid) v_seen++;
        end
        tests_run++;
        if (rd_seen != 0 || v_seen != 0) begin
            tests_failed++; $display("FAIL empty: rd_en cycles=%0d valid cycles=%0d required 0", rd_seen, v_seen);
        end
    endtask

    task automatic test_error_reset();
        int waited = 0;
        logic [15:0] e;
        do_reset();
        load_words(8, 1'b0, 16'h0100);
        m_ready = 1'b1; enable = 1'b1;
        do begin @(negedge clk); waited++; end while (!fifo_rd_en && waited < 20);
        force_uf = 1'b1;
        @(negedge clk);
        force_uf = 1'b0;
        void'(exp_q.pop_front());
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests_run++;
            if (underflow_err !== 1'b1) begin
                tests_failed++; $display("FAIL err_sticky: got %b required 1", underflow_err);
            end
            if (m_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hBEEF;
                tests_run++;
                if (m_data !== e) begin
                    tests_failed++; $display("FAIL err_data: got %h required %h", m_data, e);
                end
            end
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("midstream_reset_async");
        @(posedge clk); #1;
        check_all_zero("midstream_reset_next");
        @(negedge clk);
        enable = 1'b0;
        rst_n = 1'b1;
        #1;
        check_all_zero("after_reset_release");
    endtask

    task automatic test_random();
        int hs = 0;
        logic stall = 1'b0;
        logic [15:0] held = 16'h0000, e;
        do_reset();
        load_words(40, 1'b1, 16'h0000);
        enable = 1'b1;
        for (int c = 0; c < 800 && hs < 40; c++) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            if (stall) begin
                tests_run++;
                if (!m_valid || m_data !== held) begin
                    tests_failed++;
                    $display("FAIL rand_hold: valid=%b data=%h required valid=1 data=%h", m_valid, m_data, held);
                end
            end
            stall = m_valid && !m_ready;
            held = m_data;
            if (m_valid && m_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hBEEF;
                tests_run++;
                if (m_data !== e) begin
                    tests_failed++; $display("FAIL rand_data: got %h required %h", m_data, e);
                end
                hs++;
            end
        end
        @(negedge clk);
        tests_run++;
        if (hs != 40 || words_out !== 16'd40) begin
            tests_failed++; $display("FAIL rand_total: hs=%0d words=%0d required 40", hs, words_out);
        end
    endtask

    task automatic test_wrap();
        int hs = 0;
        do_reset();
        for (int i = 0; i < 65536; i++) fq.push_back(16'(i));
        m_ready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 70000 && hs < 65536; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                if (hs == 65535) begin
                    tests_run++;
                    if (words_out !== 16'hFFFF) begin
                        tests_failed++; $display("FAIL wrap_max: got %h required ffff", words_out);
                    end
                end
                hs++;
            end
        end
        @(negedge clk);
        tests_run++;
        if (hs != 65536 || words_out !== 16'h0000) begin
            tests_failed++; $display("FAIL wrap_zero: hs=%0d words=%h required 65536 and 0000", hs, words_out);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_empty();
        test_error_reset();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
